// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci result path: FSM states,
// default widths and the BCD digit type.
package fib_pkg;

    localparam int unsigned FIB_WIDTH      = 32;
    localparam int unsigned FIB_BCD_DIGITS = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } fib_state_e;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/fib_bcd_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module fib_bcd_digit
    import fib_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);

    always_comb begin
        d_out = (d_in >= 4'd5) ? bcd_digit_t'(d_in + 4'd3) : d_in;
    end

endmodule

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-packed-BCD converter (one bit per clock) with valid/ready
// handshakes on both sides. Define FIB_BCD_DIGCNT_EN to add the out_digits port.
module fib_bcd_conv
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH  = FIB_WIDTH,
    parameter int unsigned DIGITS = FIB_BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
`ifdef FIB_BCD_DIGCNT_EN
    ,
    output logic [3:0]            out_digits
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    fib_state_e            state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [4*DIGITS-1:0]   bcd_corr;
    logic [4*DIGITS-1:0]   bcd_shift;
    logic [WIDTH-1:0]      bin_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        fib_bcd_digit u_digit (
            .d_in  (bcd_q[4*g +: 4]),
            .d_out (bcd_corr[4*g +: 4])
        );
    end

    // {BCD, binary} shifts as one register; the binary MSB enters the units digit.
    always_comb begin
        bcd_shift = {bcd_corr[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_shift = {bin_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_data;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_bcd   = bcd_q;
    end

`ifdef FIB_BCD_DIGCNT_EN
    logic [3:0] digits_q, digits_d;
    logic [3:0] digits_n;

    // Significant digits of the final shifted value; zero still counts as one.
    always_comb begin
        digits_n = 4'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                digits_n = 4'(i + 1);
            end
        end
    end

    always_comb begin
        digits_d = digits_q;
        if (state_q == S_IDLE && in_valid) begin
            digits_d = '0;
        end else if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
            digits_d = digits_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

    always_comb begin
        out_digits = digits_q;
    end
`endif

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv against a decimal-arithmetic reference.
module tb_fib_bcd_conv;

    localparam int unsigned W = 32;
    localparam int unsigned D = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [4*D-1:0]   out_bcd;
    logic             busy;
`ifdef FIB_BCD_DIGCNT_EN
    logic [3:0]       out_digits;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    fib_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
`ifdef FIB_BCD_DIGCNT_EN
        ,
        .out_digits(out_digits)
`endif
    );

    function automatic logic [4*D-1:0] ref_bcd(input logic [W-1:0] v);
        logic [4*D-1:0] r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ref_digits(input logic [W-1:0] v);
        longint unsigned x;
        int n;
        x = longint'(v);
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    // Present v, wait for acceptance, then count edges until out_valid.
    task automatic do_conv(input logic [W-1:0] v, output int lat, output logic [4*D-1:0] bcd);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bcd = out_bcd;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== '0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_bcd=%h, required 0 0 0 0",
                     in_ready, out_valid, busy, out_bcd);
        end
`ifdef FIB_BCD_DIGCNT_EN
        tests++;
        if (out_digits !== 4'd0) begin
            fails++;
            $display("FAIL reset_digits: got %0d required 0", out_digits);
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] v, input logic [4*D-1:0] exp);
        int lat;
        logic [4*D-1:0] bcd;
        do_conv(v, lat, bcd);
        tests++;
        if (lat != W) begin
            fails++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, W);
        end
        tests++;
        if (bcd !== exp) begin
            fails++;
            $display("FAIL %s_bcd: got %h required %h", name, bcd, exp);
        end
`ifdef FIB_BCD_DIGCNT_EN
        tests++;
        if (out_digits !== 4'(ref_digits(v))) begin
            fails++;
            $display("FAIL %s_digits: got %0d required %0d", name, out_digits, ref_digits(v));
        end
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_handshake: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_directed;
        check_result("zero",   32'd0,          40'h00_0000_0000);
        check_result("fib21",  32'd10946,      40'h00_0001_0946);
        check_result("fib45",  32'd1134903170, 40'h11_3490_3170);
        check_result("allone", 32'hFFFF_FFFF,  40'h42_9496_7295);
    endtask

    task automatic test_random;
        logic [W-1:0] v;
        for (int k = 0; k < 12; k++) begin
            v = $urandom;
            if (k % 3 == 1) v = v >> $urandom_range(31, 1);
            check_result("random", v, ref_bcd(v));
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [4*D-1:0] bcd;
        logic [W-1:0] v;
        int bad;
        v = $urandom;
        do_conv(v, lat, bcd);
        tests++;
        if (bcd !== ref_bcd(v) || lat != W) begin
            fails++;
            $display("FAIL bp_result: got %h lat %0d required %h lat %0d", bcd, lat, ref_bcd(v), W);
        end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_bcd !== ref_bcd(v)) bad++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_bcd !== ref_bcd(v)) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b out_bcd=%h required 0 1 0 %h",
                     out_valid, in_ready, busy, out_bcd, ref_bcd(v));
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [4*D-1:0] bcd;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd1134903170;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_bcd !== '0) begin
            fails++;
            $display("FAIL midreset_state: in_ready=%b out_valid=%b busy=%b out_bcd=%h required 0 0 0 0",
                     in_ready, out_valid, busy, out_bcd);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
        check_result("after_reset", 32'd1, 40'h00_0000_0001);
    endtask

    task automatic test_back_to_back;
        int first, second, seen, cyc;
        logic [W-1:0] v;
        logic [4*D-1:0] got;
        v = $urandom;
        first = -1; second = -1; seen = 0; got = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        cyc = 0;
        while (second < 0 && cyc < 200) begin
            if (in_ready) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (out_valid && seen == 0) begin
                got  = out_bcd;
                seen = 1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        tests++;
        if (second - first != W + 2) begin
            fails++;
            $display("FAIL b2b_period: got %0d required %0d", second - first, W + 2);
        end
        tests++;
        if (seen != 1 || got !== ref_bcd(v)) begin
            fails++;
            $display("FAIL b2b_result: got %h (seen %0d) required %h", got, seen, ref_bcd(v));
        end
        repeat (W + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
